i2c_slave_frontend: RTL

Bit-level I2C slave front end that sits directly upstream of `I2C_SLAVE_MEMORY`. It synchronises the open-drain SCL/SDA pins and detects START, repeated START and STOP. It decodes the 7-bit device address, captures the register pointer byte, and presents it to the memory as Enable/RorW/DirectionBuffer. It then shifts write bytes into the memory's input buffer, or shifts the memory's output buffer back to the master, driving ACK/NACK from the memory's AddressFound.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_line_sync.sv | 51 +++++
 rtl/i2c_slave_frontend.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave front end: FSM states, byte length, default address.
package i2c_pkg;

  localparam logic [3:0] I2C_BITS_PER_BYTE      = 4'd8;
  localparam logic [6:0] I2C_DEFAULT_SLAVE_ADDR = 7'h48;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Pin conditioner: 2-FF synchroniser, optional 3-sample majority filter
// (I2C_GLITCH_FILTER_EN), and rise/fall strobes on the conditioned level.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, prev_q;

  // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= pin;
      s2_q <= s1_q;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic h1_q, h2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1_q <= 1'b1;
      h2_q <= 1'b1;
    end else begin
      h1_q <= s2_q;
      h2_q <= h1_q;
    end
  end

  assign level = (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
`else
  assign level = s2_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_frontend.sv
// Bit-level I2C slave front end for I2C_SLAVE_MEMORY: bus condition detection,
// address decode, byte shifting and ACK generation. Optional filter: I2C_GLITCH_FILTER_EN.
module i2c_slave_frontend
  import i2c_pkg::*;
#(
  parameter int unsigned ADDRESSLENGTH = 8,
  parameter logic [6:0]  SLAVE_ADDR    = I2C_DEFAULT_SLAVE_ADDR
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe,
  output logic                     mem_enable,
  output logic                     mem_rorw,
  output logic [ADDRESSLENGTH-1:0] mem_addr,
  input  logic                     mem_addr_found,
  output logic [7:0]               mem_wdata,
  output logic                     mem_wstrobe,
  input  logic [7:0]               mem_rdata,
  output logic                     mem_rstrobe,
  output logic                     busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (.clk(sys_clk), .rst(rst), .pin(scl_i),
                            .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda_sync (.clk(sys_clk), .rst(rst), .pin(sda_i),
                            .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  i2c_state_e               state_q, state_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               shift_q, shift_d, shift_in;
  logic                     ack_phase_q, ack_phase_d;
  logic                     sda_oe_q, sda_oe_d;
  logic                     rorw_q, rorw_d;
  logic [ADDRESSLENGTH-1:0] addr_q, addr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     enable_q, enable_d;
  logic                     wstrobe_q, wstrobe_d;
  logic                     rstrobe_q, rstrobe_d;
  logic                     busy_q, busy_d;
  logic                     start_det, stop_det, byte_done;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign shift_in  = {shift_q[6:0], sda_lvl};
  assign byte_done = scl_rise && (bit_cnt_q == I2C_BITS_PER_BYTE - 4'd1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_phase_d = ack_phase_q;
    sda_oe_d    = sda_oe_q;
    rorw_d      = rorw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    enable_d    = 1'b0;
    wstrobe_d   = 1'b0;
    rstrobe_d   = 1'b0;
    busy_d      = busy_q;

    // Write-side pointer bump waits one cycle so the strobe sees the old address.
    if (wstrobe_q) begin
      addr_d   = addr_q + ADDRESSLENGTH'(1);
      enable_d = 1'b1;
    end
    if (rstrobe_q) shift_d = mem_rdata;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d     = ST_DEV_ADDR;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
          if (byte_done) begin
            bit_cnt_d   = '0;
            ack_phase_d = 1'b0;
            if (state_q == ST_DEV_ADDR) begin
              if (shift_in[7:1] == SLAVE_ADDR) begin
                rorw_d  = shift_in[0];
                state_d = ST_DEV_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else if (state_q == ST_REG_ADDR) begin
              addr_d   = ADDRESSLENGTH'(shift_in);
              enable_d = 1'b1;
              state_d  = ST_REG_ACK;
            end else begin
              wdata_d   = shift_in;
              wstrobe_d = 1'b1;
              state_d   = ST_WR_ACK;
            end
          end
        end
        // First falling edge opens the ACK slot, the next one closes it;
        // sda_oe_q at close records whether the slot was acknowledged.
        ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              sda_oe_d    = (state_q == ST_REG_ACK) ? mem_addr_found : 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (!sda_oe_q)                 state_d = ST_WAIT_STOP;
              else if (state_q == ST_DEV_ACK) state_d = ST_REG_ADDR;
              else                           state_d = ST_WR_BYTE;
            end
          end else if (scl_rise && ack_phase_q && state_q == ST_DEV_ACK && rorw_q) begin
            rstrobe_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_RD_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (byte_done) begin
              bit_cnt_d = '0;
              addr_d    = addr_q + ADDRESSLENGTH'(1);
              enable_d  = 1'b1;
              state_d   = ST_RD_ACK;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_lvl) begin
              rstrobe_d = 1'b1;
              state_d   = ST_RD_BYTE;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_IDLE, ST_WAIT_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ack_phase_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      rorw_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      enable_q    <= 1'b0;
      wstrobe_q   <= 1'b0;
      rstrobe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_phase_q <= ack_phase_d;
      sda_oe_q    <= sda_oe_d;
      rorw_q      <= rorw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      enable_q    <= enable_d;
      wstrobe_q   <= wstrobe_d;
      rstrobe_q   <= rstrobe_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign mem_enable  = enable_q;
  assign mem_rorw    = rorw_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrobe = wstrobe_q;
  assign mem_rstrobe = rstrobe_q;
  assign busy        = busy_q;

endmodule
